// File: rtl/dmem_bridge.sv
// MEM-stage to req/ack data memory bridge: stalls 1 + memory latency cycles, then a 1-cycle DONE with stallM low.
// Backpressure: holds the pipeline via stallM; a request stays up until mem_ack or the TIMEOUT abort.
module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    output logic [31:0] rdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        buserrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        access;
    logic        aligned;
    logic        start;
    logic        misalign;
    logic        ack_hit;
    logic        tmo_hit;

    assign access  = memreadM | memwriteM;
    assign aligned = (addrM[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE never starts a request: the instruction that just completed is still on the inputs.
    always_comb begin
        state_nxt = state;
        stallM    = 1'b0;
        start     = 1'b0;
        misalign  = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    stallM    = 1'b1;
                    start     = 1'b1;
                    state_nxt = BUSY;
                end else if (access) begin
                    misalign  = 1'b1;
                end
            end
            BUSY: begin
                stallM = 1'b1;
                if (mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdataM    <= 32'd0;
            cnt       <= 16'd0;
            adelM     <= 1'b0;
            adesM     <= 1'b0;
            buserrM   <= 1'b0;
        end else begin
            adelM   <= misalign & ~memwriteM;
            adesM   <= misalign & memwriteM;
            buserrM <= tmo_hit;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= memwriteM;
                mem_addr  <= {addrM[31:2], 2'b00};
                mem_wdata <= wdataM;
                cnt       <= 16'd0;
            end else if (ack_hit || tmo_hit) begin
                mem_req <= 1'b0;
            end else if (state == BUSY) begin
                cnt <= cnt + 16'd1;
            end
            // mem_we still describes the transaction that is finishing.
            if (ack_hit && !mem_we) begin
                rdataM <= mem_rdata;
            end else if (tmo_hit && !mem_we) begin
                rdataM <= ERR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized scoreboard bench for dmem_bridge with a word-array memory responder.
module tb_dmem_bridge;

    localparam int          TO  = 6;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memreadM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [31:0] addrM = 32'd0;
    logic [31:0] wdataM = 32'd0;
    logic [31:0] rdataM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic        buserrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .memreadM(memreadM), .memwriteM(memwriteM), .addrM(addrM), .wdataM(wdataM),
        .rdataM(rdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM), .buserrM(buserrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] reqlen;
    } txn_t;

    typedef struct packed {
        logic [15:0] stall;
        logic [31:0] rdata;
        logic        berr;
    } res_t;

    typedef struct packed {
        logic adel;
        logic ades;
    } flg_t;

    txn_t txn_q[$];
    res_t res_q[$];
    flg_t flg_q[$];
    int   lat_q[$];

    int checks = 0;
    int errors = 0;
    int exp_berr = 0;
    int seen_berr = 0;

    logic [31:0] mem_arr[64];
    logic [31:0] ref_mem[64];
    logic [31:0] last_rd = 32'd0;

    bit mon_en = 0;
    bit resp_en = 0;
    bit stray_go = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory responder: ack in the lat-th cycle of the request (lat outside 1..TO never acks).
    int k = 0;
    int cur_lat = 0;
    always @(negedge clk) begin
        if (stray_go) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5555_5555;
        end else if (resp_en && mem_req) begin
            k++;
            if (k == 1) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            if (k == cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
                else        mem_rdata = mem_arr[mem_addr[7:2]];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            k       = 0;
            mem_ack = 1'b0;
        end
    end

    // Monitor: pops expectations when the DUT shows a request, a completion or a flag.
    logic prev_req = 1'b0;
    logic prev_stall = 1'b0;
    int   run = 0;
    int   reqcnt = 0;
    txn_t cur = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req) begin
                if (!prev_req) begin
                    reqcnt = 1;
                    if (txn_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL txn_unexpected actual addr=%h required none", mem_addr);
                        cur = '0;
                    end else begin
                        cur = txn_q.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(cur.we));
                        chk("mem_addr", mem_addr, cur.addr);
                        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    reqcnt++;
                    chk("hold_we", 32'(mem_we), 32'(cur.we));
                    chk("hold_addr", mem_addr, cur.addr);
                    if (cur.we) chk("hold_wdata", mem_wdata, cur.wdata);
                end
            end else if (prev_req) begin
                chk("req_len", 32'(reqcnt), 32'(cur.reqlen));
            end
            prev_req = mem_req;

            if (stallM) begin
                run++;
            end else if (run > 0) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual stall=%0d required none", run);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("stall_len", 32'(run), 32'(r.stall));
                    chk("rdataM", rdataM, r.rdata);
                    chk("buserrM", 32'(buserrM), 32'(r.berr));
                end
                run = 0;
            end else if (buserrM) begin
                checks++; errors++;
                $display("FAIL buserr_stray actual=1 required=0");
            end
            if (buserrM) seen_berr++;

            if (adelM || adesM) begin
                if (flg_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL flag_unexpected actual adel=%0b ades=%0b required none", adelM, adesM);
                end else begin
                    flg_t f;
                    f = flg_q.pop_front();
                    chk("adelM", 32'(adelM), 32'(f.adel));
                    chk("adesM", 32'(adesM), 32'(f.ades));
                    chk("mis_nostall", 32'(prev_stall), 32'd0);
                end
            end
            prev_stall = stallM;
        end
    end

    // Reference model: expectations come from the access rules, not from DUT internals.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int lat);
        logic acc;
        bit   ok;
        int   eff;
        int   n;
        txn_t t;
        res_t r;
        flg_t f;
        acc = rd | wr;
        if (acc && a[1:0] != 2'b00) begin
            f.adel = ~wr;
            f.ades = wr;
            flg_q.push_back(f);
        end else if (acc) begin
            ok  = (lat >= 1) && (lat <= TO);
            eff = ok ? lat : TO;
            t.we     = wr;
            t.addr   = {a[31:2], 2'b00};
            t.wdata  = wd;
            t.reqlen = 16'(eff);
            txn_q.push_back(t);
            lat_q.push_back(lat);
            if (wr) begin
                if (ok) ref_mem[a[7:2]] = wd;
                r.rdata = last_rd;
            end else begin
                r.rdata = ok ? ref_mem[a[7:2]] : ERR;
                last_rd = r.rdata;
            end
            r.stall = 16'(1 + eff);
            r.berr  = ~ok;
            if (!ok) exp_berr++;
            res_q.push_back(r);
        end
        memreadM  = rd;
        memwriteM = wr;
        addrM     = a;
        wdataM    = wd;
        n = 0;
        @(negedge clk);
        while (stallM && n < TO + 4) begin
            n++;
            @(negedge clk);
        end
        if (stallM) begin
            checks++; errors++;
            $display("FAIL stall_bound actual=stuck required=release within %0d cycles", TO + 4);
        end
        @(posedge clk);
        #1;
        memreadM  = 1'b0;
        memwriteM = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, off, op, lat;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 32'h1234_5678;
        ref_mem[4] = 32'h1234_5678;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdataM", rdataM, 32'd0);
        chk("rst_stallM", 32'(stallM), 32'd0);
        chk("rst_flags", 32'({adelM, adesM, buserrM}), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mon_en  = 1;
        resp_en = 1;

        issue(1, 0, 32'h0000_0010, 32'd0, 1);
        issue(0, 1, 32'h0000_0024, 32'hCAFE_BABE, 5);
        issue(1, 0, 32'h0000_0013, 32'd0, 1);
        issue(0, 1, 32'h0000_0022, 32'h1111_2222, 1);
        issue(1, 0, 32'h0000_0030, 32'd0, 0);
        issue(1, 0, 32'h0000_0040, 32'd0, 2);
        issue(1, 0, 32'h0000_0044, 32'd0, 1);
        issue(1, 1, 32'h0000_0048, 32'hA5A5_0F0F, 2);
        issue(1, 0, 32'h0000_0048, 32'd0, TO);
        issue(0, 1, 32'h0000_004C, 32'h0BAD_F00D, TO + 1);
        issue(1, 0, 32'h0000_004C, 32'd0, 3);

        for (int i = 0; i < 300; i++) begin
            op  = $urandom_range(0, 9);
            w   = $urandom_range(0, 63);
            off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            a   = 32'(w * 4 + off);
            lat = $urandom_range(0, TO + 1);
            case (op)
                0:       issue(0, 0, a, $urandom, lat);
                1, 2, 3, 4: issue(1, 0, a, $urandom, lat);
                5, 6, 7: issue(0, 1, a, $urandom, lat);
                default: issue(1, 1, a, $urandom, lat);
            endcase
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("txn_q_empty", 32'(txn_q.size()), 32'd0);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        chk("flg_q_empty", 32'(flg_q.size()), 32'd0);
        chk("buserr_total", 32'(seen_berr), 32'(exp_berr));

        mon_en = 0;
        @(posedge clk);
        #1;
        lat_q.delete();
        lat_q.push_back(5);
        memreadM = 1'b1;
        addrM    = 32'h0000_0010;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        memreadM = 1'b0;
        @(negedge clk);
        chk("mid_req_before_rst", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stallM", 32'(stallM), 32'd0);
        chk("mid_rst_rdataM", rdataM, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        resp_en = 0;
        @(posedge clk);
        #1;
        stray_go = 1;
        @(posedge clk);
        #1;
        stray_go = 0;
        @(negedge clk);
        chk("stray_rdataM", rdataM, 32'd0);
        chk("stray_mem_req", 32'(mem_req), 32'd0);
        chk("stray_stallM", 32'(stallM), 32'd0);
        @(negedge clk);
        chk("stray_mem_req2", 32'(mem_req), 32'd0);
        chk("stray_rdataM2", rdataM, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the pipeline's memory-stage data port (memory address from aluout, write data, memwriteM, plus memreadM) and a slower word-wide data memory that uses a req/ack handshake.
- Converts each single-cycle MEM-stage access into a handshake transaction.
- Holds the pipeline with stallM until the transaction completes.
- Flags misaligned addresses and handshake timeouts.

Parameters:
- TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before the access is aborted (1..65535).
- ERR_DATA, 32'hDEADBEEF, value returned on rdataM for an aborted read.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- memreadM  in  1  load in MEM stage.
- memwriteM  in  1  store in MEM stage.
- addrM  in  32  byte address (ALU result).
- wdataM  in  32  store data.
- rdataM  out  32  load data to writeback mux.
- stallM  out  1  freeze IF..MEM pipeline registers while high.
- adelM  out  1  1-cycle pulse: misaligned load.
- adesM  out  1  1-cycle pulse: misaligned store.
- buserrM  out  1  1-cycle pulse: handshake timeout.
- mem_req  out  1  request to memory, registered.
- mem_we  out  1  1=write, registered.
- mem_addr  out  32  word-aligned address, registered.
- mem_wdata  out  32  registered store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  1-cycle completion strobe.

Behaviour:
- Access definition: access = memreadM | memwriteM. When both inputs are high, the access is treated as a write.
- Reset values (the synchronous reset dominates any event in the same cycle):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdataM=0, timeout counter=0.
  - adelM/adesM/buserrM=0.
- Reset mid-transaction: mem_req drops at the next edge with no wait for ack. A late mem_ack arriving in IDLE is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Aligned access (addrM[1:0]==0):
    - stallM=1 combinationally in the same cycle.
    - At the edge: register mem_we, mem_addr={addrM[31:2],2'b00}, mem_wdata; set mem_req=1; clear the counter; go to BUSY.
  - Misaligned access:
    - No request is issued and stallM stays 0.
    - adelM (read) or adesM (write) is registered high for exactly one cycle, following the access cycle.
    - State stays IDLE.
  - No access: stallM=0.
- BUSY:
  - stallM=1. mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On mem_ack:
    - mem_req=0 at the edge.
    - For a read, rdataM<=mem_rdata; for a write, rdataM is unchanged.
    - Go to DONE.
  - On no ack:
    - The counter increments.
    - When counter==TIMEOUT-1 and there is still no ack: mem_req=0, buserrM pulses for 1 cycle, rdataM<=ERR_DATA for a read, go to DONE.
  - Ack wins over timeout in the same cycle.
- DONE:
  - stallM=0 for exactly one cycle so the pipeline advances past the completed access.
  - No new request is issued, even though memreadM/memwriteM are still high for the same instruction.
  - Next state is IDLE.
- Latency:
  - Aligned access with memory acking on the first req cycle: stallM high 2 cycles (IDLE cycle + BUSY cycle), then 1 DONE cycle.
  - General case: stall cycles = 1 + memory latency.
- rdataM holds its last value until the next completed read. It is the value consumed by the writeback stage while the load leaves MEM in the DONE cycle.
- mem_ack while not in BUSY is ignored.
- Back-to-back accesses: IDLE is re-entered after DONE, so a consecutive memory instruction starts at the cycle after DONE.

Test Plan:
- Aligned load, addr 0x0000_0010, memory acks 1 cycle after req with mem_rdata=0x1234_5678:
  - mem_addr=0x10, mem_we=0.
  - stallM high 2 cycles, then low in DONE.
  - rdataM=0x1234_5678.
  - Exactly one mem_req transaction.
- Aligned store, addr 0x0000_0024, wdata 0xCAFEBABE, ack after 5 cycles:
  - mem_we=1, mem_wdata=0xCAFEBABE held stable for all 5 req cycles.
  - stallM high 6 cycles.
  - rdataM unchanged.
- Misaligned load at 0x0000_0013 and misaligned store at 0x0000_0022:
  - No mem_req; stallM=0.
  - adelM (load) and adesM (store) each one-cycle pulses.
- Timeout with TIMEOUT=4 and no ack on a load:
  - mem_req high 4 cycles.
  - buserrM pulses once.
  - rdataM=0xDEADBEEF; state returns to IDLE.
- Reset asserted during BUSY (2 cycles into a 5-cycle access):
  - mem_req=0 and stallM=0 at the next edge.
  - A subsequent stray mem_ack produces no rdataM change and no new request.
- Two consecutive loads (0x40 then 0x44) and a simultaneous read+write:
  - The loads are issued in order, with one DONE cycle between them.
  - The simultaneous read+write access is issued with mem_we=1.
